// File: rtl/ascon_params.sv
// Shared ASCON permutation parameters, sequencer state encoding and the
// round-constant helper.
package ascon_params;

  localparam int d     = 1;
  localparam int LANES = 8;
  localparam int COLS  = 64 / LANES;
  localparam int RND_W = LANES * 5 * d * (d + 1) / 2;

  typedef enum logic [2:0] {
    IDLE,
    ADD_CONST,
    SBOX,
    DRAIN,
    LINEAR,
    DONE
  } perm_state_t;

  // Round constant for absolute round index i (0..11): high nibble 15-i, low nibble i.
  function automatic logic [7:0] ascon_rc(input logic [3:0] i);
    return {4'(4'd15 - i), i};
  endfunction

  function automatic logic nr_legal(input logic [3:0] nr);
    return (nr == 4'd6) || (nr == 4'd8) || (nr == 4'd12);
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the masked ASCON permutation: constant addition,
// column-group S-box issue with PRNG handshake, and linear layer.
module ascon_perm_ctrl
  import ascon_params::*;
#(
  parameter int  LANES = ascon_params::LANES,
  localparam int COLS  = 64 / LANES,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    nr,
  input  logic          masked_en,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          pc_add,
  output logic [7:0]    rc,
  output logic          sb_issue,
  output logic [CW-1:0] sb_col,
  output logic          sb_wb,
  output logic [CW-1:0] sb_wb_col,
  output logic          pl_en,
  output logic          sel_masked_round
);

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  perm_state_t   r_state;
  perm_state_t   w_next;
  logic [3:0]    r_nr;
  logic [3:0]    r_round;
  logic [CW-1:0] r_col;
  logic          r_masked;
  logic          r_wb;
  logic [CW-1:0] r_wb_col;
  logic          r_err;

  logic          w_issue;
  logic          w_rnd_ready;
  logic          w_start_ok;
  logic          w_err_set;
  logic          w_round_inc;
  logic [3:0]    w_rc_idx;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_rnd_ready = 1'b0;
    w_start_ok  = 1'b0;
    w_err_set   = 1'b0;
    w_round_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (nr_legal(nr)) begin
            w_start_ok = 1'b1;
            w_next     = ADD_CONST;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ADD_CONST: w_next = SBOX;
      SBOX: begin
        // Masked beats wait for fresh randomness; unmasked beats never stall.
        w_issue     = r_masked ? rnd_valid : 1'b1;
        w_rnd_ready = r_masked & rnd_valid;
        if (w_issue && (r_col == LAST_COL)) w_next = DRAIN;
      end
      DRAIN: w_next = LINEAR;
      LINEAR: begin
        if (r_round == (r_nr - 4'd1)) begin
          w_next = DONE;
        end else begin
          w_next      = ADD_CONST;
          w_round_inc = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_nr     <= '0;
      r_round  <= '0;
      r_col    <= '0;
      r_masked <= 1'b0;
      r_wb     <= 1'b0;
      r_wb_col <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_set;
      // S-box output registers capture every cycle, so write-back trails issue by one.
      r_wb     <= w_issue;
      r_wb_col <= r_col;
      if (w_start_ok) begin
        r_nr     <= nr;
        r_masked <= masked_en;
        r_round  <= '0;
        r_col    <= '0;
      end
      if (w_round_inc) r_round <= r_round + 4'd1;
      if (w_issue) r_col <= (r_col == LAST_COL) ? '0 : r_col + CW'(1);
    end
  end

  assign w_rc_idx         = 4'd12 - r_nr + r_round;
  assign pc_add           = (r_state == ADD_CONST);
  assign rc               = pc_add ? ascon_rc(w_rc_idx) : 8'h00;
  assign sb_issue         = w_issue;
  assign sb_col           = r_col;
  assign sb_wb            = r_wb;
  assign sb_wb_col        = r_wb_col;
  assign pl_en            = (r_state == LINEAR);
  assign rnd_ready        = w_rnd_ready;
  assign busy             = (r_state != IDLE);
  assign done             = (r_state == DONE);
  assign err              = r_err;
  assign sel_masked_round = r_masked;

endmodule
